// File: rtl/lpc_frame_buffer_pkg.sv
// rtl/lpc_frame_buffer_pkg.sv - shared types and defaults for the LPC frame buffer
package lpc_frame_buffer_pkg;

  localparam int DEF_SAMPLE_W  = 16;
  localparam int DEF_MAX_ORDER = 12;

  typedef enum logic [1:0] {
    BANK_FREE     = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_WAITING  = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  function automatic int sat_order(input int order, input int max_order);
    return (order > max_order) ? max_order : order;
  endfunction

endpackage

// File: rtl/lpc_frame_ram.sv
// rtl/lpc_frame_ram.sv - simple dual-port sample store with registered read
module lpc_frame_ram
  import lpc_frame_buffer_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int DEPTH    = 16384,
  parameter int ADDR_W   = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register is cleared so the buffer output reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lpc_frame_buffer.sv
// rtl/lpc_frame_buffer.sv - block-framed sample delay buffer feeding the LPC residual filter
module lpc_frame_buffer
  import lpc_frame_buffer_pkg::*;
#(
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int BLOCK_SIZE = 4096,
  parameter int NUM_BANKS  = 4,
  parameter int MAX_ORDER  = DEF_MAX_ORDER,
  localparam int ORDER_W   = $clog2(MAX_ORDER + 1)
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iEnable,
  input  logic                iValid,
  input  logic [SAMPLE_W-1:0] iSample,
  input  logic                iModelValid,
  input  logic [ORDER_W-1:0]  iModelOrder,
  output logic                oValid,
  output logic [SAMPLE_W-1:0] oSample,
  output logic                oWarmup,
  output logic [ORDER_W-1:0]  oOrder,
  output logic                oBlockStart,
  output logic                oBlockEnd,
  output logic                oFull,
  output logic                oOverflow,
  output logic                oModelError
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int IDX_W  = $clog2(BLOCK_SIZE);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLOCK_SIZE - 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  bank_state_t          state [NUM_BANKS];
  logic [NUM_BANKS-1:0] model_loaded;
  logic [ORDER_W-1:0]   order_q [NUM_BANKS];
  logic [BANK_W-1:0]    wr_bank, mdl_bank, rd_bank;
  logic [IDX_W-1:0]     wr_idx, rd_idx;

  logic                 valid_q, warmup_q, start_q, end_q, overflow_q, model_error_q;
  logic [ORDER_W-1:0]   order_out_q;

  logic                 wr_open, wr_accept, wr_last, mdl_ok, rd_issue, rd_last, any_free;
  logic [ORDER_W-1:0]   mdl_order;

  function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
    return (b == LAST_BANK) ? '0 : b + 1'b1;
  endfunction

  always_comb begin
    wr_open   = (state[wr_bank] == BANK_FREE) || (state[wr_bank] == BANK_FILLING);
    wr_accept = iValid && wr_open;
    wr_last   = wr_accept && (wr_idx == LAST_IDX);
    // A block finishing this very cycle may already take its model.
    mdl_ok    = ((state[mdl_bank] == BANK_WAITING) && !model_loaded[mdl_bank]) ||
                (wr_last && (mdl_bank == wr_bank));
    rd_issue  = (state[rd_bank] == BANK_DRAINING) ||
                ((state[rd_bank] == BANK_WAITING) && model_loaded[rd_bank]);
    rd_last   = rd_issue && (rd_idx == LAST_IDX);
    mdl_order = ORDER_W'(sat_order(int'(iModelOrder), MAX_ORDER));
    any_free  = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (state[i] == BANK_FREE) any_free = 1'b1;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state[i]   <= BANK_FREE;
        order_q[i] <= '0;
      end
      model_loaded  <= '0;
      wr_bank       <= '0;
      mdl_bank      <= '0;
      rd_bank       <= '0;
      wr_idx        <= '0;
      rd_idx        <= '0;
      valid_q       <= 1'b0;
      warmup_q      <= 1'b0;
      start_q       <= 1'b0;
      end_q         <= 1'b0;
      order_out_q   <= '0;
      overflow_q    <= 1'b0;
      model_error_q <= 1'b0;
    end else if (iEnable) begin
      if (wr_accept) begin
        state[wr_bank] <= wr_last ? BANK_WAITING : BANK_FILLING;
        wr_idx         <= wr_last ? '0 : wr_idx + 1'b1;
        if (wr_last) wr_bank <= next_bank(wr_bank);
      end else if (iValid) begin
        overflow_q <= 1'b1;
      end

      if (iModelValid) begin
        if (mdl_ok) begin
          model_loaded[mdl_bank] <= 1'b1;
          order_q[mdl_bank]      <= mdl_order;
          mdl_bank               <= next_bank(mdl_bank);
        end else begin
          model_error_q <= 1'b1;
        end
      end

      // Write and read banks are never the same: their state sets are disjoint.
      if (rd_issue) begin
        if (rd_last) begin
          state[rd_bank]        <= BANK_FREE;
          model_loaded[rd_bank] <= 1'b0;
          rd_idx                <= '0;
          rd_bank               <= next_bank(rd_bank);
        end else begin
          state[rd_bank] <= BANK_DRAINING;
          rd_idx         <= rd_idx + 1'b1;
        end
      end

      valid_q <= rd_issue;
      if (rd_issue) begin
        warmup_q    <= int'(rd_idx) < int'(order_q[rd_bank]);
        start_q     <= (rd_idx == '0);
        end_q       <= rd_last;
        order_out_q <= order_q[rd_bank];
      end else begin
        warmup_q <= 1'b0;
        start_q  <= 1'b0;
        end_q    <= 1'b0;
      end
    end
  end

  lpc_frame_ram #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (NUM_BANKS * BLOCK_SIZE),
    .ADDR_W   (BANK_W + IDX_W)
  ) u_ram (
    .clk      (iClock),
    .rst      (iReset),
    .wr_en    (iEnable && wr_accept),
    .wr_addr  ({wr_bank, wr_idx}),
    .wr_data  (iSample),
    .rd_en    (iEnable && rd_issue),
    .rd_addr  ({rd_bank, rd_idx}),
    .rd_data  (oSample)
  );

  assign oValid      = valid_q;
  assign oWarmup     = warmup_q;
  assign oOrder      = order_out_q;
  assign oBlockStart = start_q;
  assign oBlockEnd   = end_q;
  assign oFull       = !any_free && !wr_open;
  assign oOverflow   = overflow_q;
  assign oModelError = model_error_q;

endmodule

// File: tb/tb_lpc_frame_buffer.sv
// tb/tb_lpc_frame_buffer.sv - directed self-checking bench for lpc_frame_buffer
module tb_lpc_frame_buffer;

  localparam int SW = 16;
  localparam int BS = 8;
  localparam int NB = 2;
  localparam int MO = 4;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1, en = 1'b1, vin = 1'b0, mv = 1'b0;
  logic [SW-1:0] smp = '0;
  logic [OW-1:0] mo = '0;
  logic          ov, ow, obs, obe, ofull, oovf, omerr;
  logic [SW-1:0] os;
  logic [OW-1:0] oo;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int model_cycle;
  logic [21:0] rec_q [$];
  int          cyc_q [$];

  always #5 clk = ~clk;

  lpc_frame_buffer #(
    .SAMPLE_W   (SW),
    .BLOCK_SIZE (BS),
    .NUM_BANKS  (NB),
    .MAX_ORDER  (MO)
  ) dut (
    .iClock      (clk),
    .iReset      (rst),
    .iEnable     (en),
    .iValid      (vin),
    .iSample     (smp),
    .iModelValid (mv),
    .iModelOrder (mo),
    .oValid      (ov),
    .oSample     (os),
    .oWarmup     (ow),
    .oOrder      (oo),
    .oBlockStart (obs),
    .oBlockEnd   (obe),
    .oFull       (ofull),
    .oOverflow   (oovf),
    .oModelError (omerr)
  );

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs_v, exp_v);
    end
  endtask

  // One clock; records an output beat only when that edge was enabled.
  task automatic tick();
    logic e;
    e = en;
    @(posedge clk);
    #1;
    cycle++;
    if (e && ov) begin
      rec_q.push_back({os, ow, obs, obe, oo});
      cyc_q.push_back(cycle);
    end
  endtask

  task automatic idle(input int n);
    vin = 1'b0;
    mv  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; vin = 1'b0; mv = 1'b0;
    tick(); tick();
    rst = 1'b0;
    rec_q.delete();
    cyc_q.delete();
  endtask

  task automatic stream(input int base, input int n, input int mdl_at, input int m);
    for (int i = 0; i < n; i++) begin
      vin = 1'b1;
      smp = SW'(base + i);
      mv  = (i == mdl_at);
      mo  = OW'(m);
      tick();
    end
    vin = 1'b0;
    mv  = 1'b0;
  endtask

  task automatic model(input int m);
    mv = 1'b1;
    mo = OW'(m);
    tick();
    model_cycle = cycle;
    mv = 1'b0;
  endtask

  task automatic check_block(input string tag, input int first, input int base, input int m, input bit gaps);
    int ms;
    logic [21:0] exp;
    ms = (m > MO) ? MO : m;
    for (int j = 0; j < BS; j++) begin
      if (first + j < rec_q.size()) begin
        exp = {SW'(base + j), (j < ms), (j == 0), (j == BS - 1), OW'(ms)};
        chk($sformatf("%s_beat%0d", tag, j), 32'(rec_q[first + j]), 32'(exp));
        if (gaps && j > 0)
          chk($sformatf("%s_gap%0d", tag, j), cyc_q[first + j], cyc_q[first + j - 1] + 1);
      end
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_outputs", {ov, os, ow, oo, obs, obe, ofull, oovf, omerr}, 32'd0);

    // Single block, model after completion
    stream(0, 8, -1, 0);
    chk("t1_no_early_out", rec_q.size(), 0);
    model(2);
    idle(12);
    chk("t1_count", rec_q.size(), 8);
    if (rec_q.size() > 0) chk("t1_latency", cyc_q[0], model_cycle + 1);
    check_block("t1", 0, 0, 2, 1'b1);
    chk("t1_valid_low_after", ov, 1'b0);

    // Two continuous blocks, models as each block completes
    do_reset();
    stream(0, 8, 7, 1);
    stream(8, 8, 7, 4);
    idle(12);
    chk("t2_count", rec_q.size(), 16);
    check_block("t2a", 0, 0, 1, 1'b1);
    check_block("t2b", 8, 8, 4, 1'b1);
    if (rec_q.size() > 8) chk("t2_no_bubble", cyc_q[8], cyc_q[7] + 1);
    chk("t2_no_model_error", omerr, 1'b0);

    // Overflow with no models, then drain both blocks
    do_reset();
    stream(0, 16, -1, 0);
    chk("t3_full", ofull, 1'b1);
    chk("t3_no_overflow_yet", oovf, 1'b0);
    stream(16, 8, -1, 0);
    chk("t3_overflow", oovf, 1'b1);
    chk("t3_still_full", ofull, 1'b1);
    chk("t3_no_out", rec_q.size(), 0);
    model(0);
    idle(12);
    chk("t3_count_a", rec_q.size(), 8);
    check_block("t3a", 0, 0, 0, 1'b1);
    chk("t3_not_full", ofull, 1'b0);
    model(3);
    idle(12);
    chk("t3_count_b", rec_q.size(), 16);
    check_block("t3b", 8, 8, 3, 1'b1);

    // Model with empty buffer, then saturated order
    do_reset();
    model(2);
    idle(5);
    chk("t4_model_error", omerr, 1'b1);
    chk("t4_no_out", rec_q.size(), 0);
    stream(0, 8, 7, 7);
    idle(12);
    chk("t4_count", rec_q.size(), 8);
    check_block("t4", 0, 0, 7, 1'b1);
    chk("t4_error_sticky", omerr, 1'b1);

    // Reset mid-drain
    do_reset();
    stream(0, 8, 7, 2);
    for (int k = 0; k < 20 && rec_q.size() < 4; k++) tick();
    chk("t5_reached_s3", rec_q.size(), 4);
    rst = 1'b1;
    tick();
    chk("t5_rst_outputs", {ov, os, ow, oo, obs, obe, ofull, oovf, omerr}, 32'd0);
    rst = 1'b0;
    rec_q.delete();
    cyc_q.delete();
    idle(12);
    chk("t5_no_stale", rec_q.size(), 0);
    stream(50, 8, 7, 1);
    idle(12);
    chk("t5_count", rec_q.size(), 8);
    check_block("t5", 0, 50, 1, 1'b1);

    // Stall mid-drain
    do_reset();
    stream(200, 8, 7, 3);
    for (int k = 0; k < 20 && rec_q.size() < 3; k++) tick();
    chk("t6_reached_s2", rec_q.size(), 3);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t6_hold_valid%0d", k), ov, 1'b1);
      chk($sformatf("t6_hold_sample%0d", k), os, 32'd202);
    end
    en = 1'b1;
    idle(12);
    chk("t6_count", rec_q.size(), 8);
    check_block("t6", 0, 200, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
